// File: rtl/battlefront_ctrl.sv
// battlefront_ctrl: lane combat sequencer; tick timing, fronts, damage broadcast, base health
module battlefront_ctrl #(
  parameter int          NUM_ENEMY       = 4,
  parameter int          NUM_PLAYER      = 4,
  parameter logic [23:0] TICK_DIV        = 24'd2_500_000,
  parameter logic [8:0]  ENEMY_BASE_POS  = 9'd0,
  parameter logic [8:0]  PLAYER_BASE_POS = 9'd300,
  parameter logic [7:0]  BASE_HEALTH     = 8'd255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [9*NUM_ENEMY-1:0]  enemyPos,
  input  logic [8*NUM_ENEMY-1:0]  enemyDamage,
  input  logic [NUM_ENEMY-1:0]    enemyAlive,
  input  logic [9*NUM_PLAYER-1:0] playerPos,
  input  logic [8*NUM_PLAYER-1:0] playerDamage,
  input  logic [NUM_PLAYER-1:0]   playerAlive,
  output logic                    moveSCEN,
  output logic                    damageSCEN,
  output logic [7:0]              enemyDamageIn,
  output logic [7:0]              playerDamageIn,
  output logic [8:0]              enemyUnitFront,
  output logic [8:0]              playerUnitFront,
  output logic [7:0]              enemyBaseHealth,
  output logic [7:0]              playerBaseHealth,
  output logic                    playerWin,
  output logic                    playerLose,
  output logic                    q_I,
  output logic                    q_Wait,
  output logic                    q_Move,
  output logic                    q_Settle,
  output logic                    q_Damage,
  output logic                    q_Over
);
  typedef enum logic [5:0] {
    QI      = 6'b000001,
    QWAIT   = 6'b000010,
    QMOVE   = 6'b000100,
    QSETTLE = 6'b001000,
    QDAMAGE = 6'b010000,
    QOVER   = 6'b100000
  } state_t;
  state_t state, next;
  logic [23:0] cnt;
  logic [10:0] e_sum, p_sum;
  logic [7:0]  e_sat, p_sat;
  logic [8:0]  e_front, p_front;
  logic        e_seen, p_seen;
  logic        tick_done;
  assign tick_done = enable && cnt == TICK_DIV - 24'd4;
  assign e_sat = |e_sum[10:8] ? 8'hFF : e_sum[7:0];
  assign p_sat = |p_sum[10:8] ? 8'hFF : p_sum[7:0];
  assign q_I      = state == QI;
  assign q_Wait   = state == QWAIT;
  assign q_Move   = state == QMOVE;
  assign q_Settle = state == QSETTLE;
  assign q_Damage = state == QDAMAGE;
  assign q_Over   = state == QOVER;
  // Frontmost alive enemy (max) and player (min), plus damage totals of alive units
  always_comb begin
    e_front = ENEMY_BASE_POS;
    p_front = PLAYER_BASE_POS;
    e_seen  = 1'b0;
    p_seen  = 1'b0;
    e_sum   = '0;
    p_sum   = '0;
    for (int i = 0; i < NUM_ENEMY; i++)
      if (enemyAlive[i]) begin
        if (!e_seen || enemyPos[9*i+:9] > e_front) e_front = enemyPos[9*i+:9];
        e_seen = 1'b1;
        e_sum  = e_sum + 11'(enemyDamage[8*i+:8]);
      end
    for (int j = 0; j < NUM_PLAYER; j++)
      if (playerAlive[j]) begin
        if (!p_seen || playerPos[9*j+:9] < p_front) p_front = playerPos[9*j+:9];
        p_seen = 1'b1;
        p_sum  = p_sum + 11'(playerDamage[8*j+:8]);
      end
  end
  // State register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= QI;
    else state <= next;
  // Next state and Moore strobes
  always_comb begin
    next       = state;
    moveSCEN   = 1'b0;
    damageSCEN = 1'b0;
    unique case (state)
      QI:      next = QWAIT;
      QWAIT:   next = tick_done ? QMOVE : QWAIT;
      QMOVE:   begin next = QSETTLE; moveSCEN = 1'b1; end
      QSETTLE: next = QDAMAGE;
      QDAMAGE: begin
        damageSCEN = 1'b1;
        next = (enemyBaseHealth == 8'd0 || playerBaseHealth == 8'd0) ? QOVER : QWAIT;
      end
      QOVER:   next = QOVER;
      default: next = QI;
    endcase
  end
  // Tick divider; holds while enable is low
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (state == QI) cnt <= '0;
    else if (state == QWAIT && enable) cnt <= tick_done ? 24'd0 : cnt + 24'd1;
  // Registered fronts, refreshed every cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      playerUnitFront <= ENEMY_BASE_POS;
      enemyUnitFront  <= PLAYER_BASE_POS;
    end else begin
      playerUnitFront <= e_front;
      enemyUnitFront  <= p_front;
    end
  // Damage broadcasts latch when leaving settle so they are stable across the damage strobe
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      playerDamageIn <= '0;
      enemyDamageIn  <= '0;
    end else if (state == QSETTLE) begin
      playerDamageIn <= e_sat;
      enemyDamageIn  <= p_sat;
    end else if (next == QOVER) begin
      playerDamageIn <= '0;
      enemyDamageIn  <= '0;
    end
  // A base takes damage only when its whole side is dead; clamp at zero
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      playerBaseHealth <= BASE_HEALTH;
      enemyBaseHealth  <= BASE_HEALTH;
    end else if (state == QSETTLE) begin
      if (!(|playerAlive))
        playerBaseHealth <= ({3'b0, playerBaseHealth} > e_sum) ? playerBaseHealth - e_sum[7:0] : 8'd0;
      if (!(|enemyAlive))
        enemyBaseHealth <= ({3'b0, enemyBaseHealth} > p_sum) ? enemyBaseHealth - p_sum[7:0] : 8'd0;
    end
  // Game-over flags, sticky until reset
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      playerWin  <= 1'b0;
      playerLose <= 1'b0;
    end else if (state == QDAMAGE) begin
      if (enemyBaseHealth == 8'd0) playerWin <= 1'b1;
      if (playerBaseHealth == 8'd0) playerLose <= 1'b1;
    end
endmodule

// File: tb/tb_battlefront_ctrl.sv
// tb_battlefront_ctrl: directed checks of tick timing, fronts, damage sums, health and reset
module tb_battlefront_ctrl;
  logic        clk = 0, reset = 1, enable = 1;
  logic [35:0] enemyPos = '0, playerPos = '0;
  logic [31:0] enemyDamage = '0, playerDamage = '0;
  logic [3:0]  enemyAlive = '0, playerAlive = '0;
  logic        moveSCEN, damageSCEN, playerWin, playerLose;
  logic [7:0]  enemyDamageIn, playerDamageIn, enemyBaseHealth, playerBaseHealth;
  logic [8:0]  enemyUnitFront, playerUnitFront;
  logic        q_I, q_Wait, q_Move, q_Settle, q_Damage, q_Over;
  int checks = 0, errors = 0;
  int n, s;
  battlefront_ctrl #(.TICK_DIV(24'd8), .BASE_HEALTH(8'h50)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .enemyPos(enemyPos), .enemyDamage(enemyDamage), .enemyAlive(enemyAlive),
    .playerPos(playerPos), .playerDamage(playerDamage), .playerAlive(playerAlive),
    .moveSCEN(moveSCEN), .damageSCEN(damageSCEN),
    .enemyDamageIn(enemyDamageIn), .playerDamageIn(playerDamageIn),
    .enemyUnitFront(enemyUnitFront), .playerUnitFront(playerUnitFront),
    .enemyBaseHealth(enemyBaseHealth), .playerBaseHealth(playerBaseHealth),
    .playerWin(playerWin), .playerLose(playerLose),
    .q_I(q_I), .q_Wait(q_Wait), .q_Move(q_Move), .q_Settle(q_Settle),
    .q_Damage(q_Damage), .q_Over(q_Over)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_qI", q_I, 1);
    chk("rst_move", moveSCEN, 0);
    chk("rst_dmg", damageSCEN, 0);
    chk("rst_pdi", playerDamageIn, 0);
    chk("rst_edi", enemyDamageIn, 0);
    chk("rst_efront", enemyUnitFront, 300);
    chk("rst_pfront", playerUnitFront, 0);
    chk("rst_phealth", playerBaseHealth, 8'h50);
    chk("rst_ehealth", enemyBaseHealth, 8'h50);
    chk("rst_flags", {playerWin, playerLose}, 0);
    // 1: tick schedule with no units alive
    reset = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("t1_move_%0d", k), moveSCEN, (k == 6 || k == 14));
      chk($sformatf("t1_dmg_%0d", k), damageSCEN, (k == 8 || k == 16));
    end
    chk("t1_pfront", playerUnitFront, 0);
    chk("t1_efront", enemyUnitFront, 300);
    // 2: fronts with dead slots ignored, one cycle latency
    enemyPos    = {9'd255, 9'd200, 9'd42, 9'd10};
    enemyAlive  = 4'b0011;
    playerPos   = {9'd100, 9'd100, 9'd100, 9'd150};
    playerAlive = 4'b0001;
    #1;
    chk("t2_pfront_old", playerUnitFront, 0);
    chk("t2_efront_old", enemyUnitFront, 300);
    @(negedge clk);
    chk("t2_pfront", playerUnitFront, 42);
    chk("t2_efront", enemyUnitFront, 150);
    // 3: saturated enemy damage sum, players alive so no base damage
    enemyAlive   = 4'b0111;
    enemyDamage  = {8'hFF, 8'h80, 8'h80, 8'h80};
    playerDamage = {8'h77, 8'h77, 8'h77, 8'h05};
    n = 0;
    do begin @(negedge clk); n++; end while (!moveSCEN && n < 40);
    chk("t3_move_seen", moveSCEN, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!damageSCEN && n < 40);
    chk("t3_dmg_seen", damageSCEN, 1);
    chk("t3_pdi", playerDamageIn, 8'hFF);
    chk("t3_edi", enemyDamageIn, 8'h05);
    chk("t3_phealth", playerBaseHealth, 8'h50);
    chk("t3_ehealth", enemyBaseHealth, 8'h50);
    chk("t3_pfront", playerUnitFront, 200);
    @(negedge clk);
    chk("t3_pdi_hold", playerDamageIn, 8'hFF);
    chk("t3_wait", q_Wait, 1);
    // 5: enable low for 20 cycles in wait delays the tick by 20
    n = 0;
    do begin @(negedge clk); n++; end while (!moveSCEN && n < 40);
    chk("t5_move_seen", moveSCEN, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 3) enable = 0;
      if (n == 10) chk("t5_hold_wait", q_Wait, 1);
      if (n == 23) enable = 1;
    end while (!moveSCEN && n < 60);
    chk("t5_period", n, 28);
    // 6: reset during settle clears everything at once
    @(negedge clk);
    chk("t6_in_settle", q_Settle, 1);
    reset = 1;
    #1;
    chk("t6_qI", q_I, 1);
    chk("t6_move", moveSCEN, 0);
    chk("t6_dmg", damageSCEN, 0);
    chk("t6_pdi", playerDamageIn, 0);
    chk("t6_edi", enemyDamageIn, 0);
    chk("t6_health", {playerBaseHealth, enemyBaseHealth}, 16'h5050);
    @(negedge clk);
    reset = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!moveSCEN && n < 40);
    chk("t6_resume_move", n, 6);
    repeat (2) @(negedge clk);
    chk("t6_resume_dmg", damageSCEN, 1);
    // 4: no players alive; player base drains 0x20 per tick to game over
    enemyAlive  = 4'b0001;
    enemyDamage = {8'hFF, 8'hFF, 8'hFF, 8'h20};
    playerAlive = 4'b0000;
    for (int t = 1; t <= 3; t++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!damageSCEN && n < 40);
      chk($sformatf("t4_dmg_seen_%0d", t), damageSCEN, 1);
      chk($sformatf("t4_phealth_%0d", t), playerBaseHealth, 8'h50 - 8'h20 * t[7:0] + ((t == 3) ? 8'h10 : 8'h00));
      chk($sformatf("t4_pdi_%0d", t), playerDamageIn, 8'h20);
      chk($sformatf("t4_lose_%0d", t), playerLose, 0);
    end
    @(negedge clk);
    chk("t4_lose", playerLose, 1);
    chk("t4_win", playerWin, 0);
    chk("t4_over", q_Over, 1);
    chk("t4_pdi_clr", playerDamageIn, 0);
    chk("t4_ehealth", enemyBaseHealth, 8'h50);
    s = 0;
    repeat (30) begin @(negedge clk); s += int'(moveSCEN) + int'(damageSCEN); end
    chk("t4_no_strobes", s, 0);
    chk("t4_still_over", q_Over, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/battlefront_ctrl.md
Name: battlefront_ctrl

Overview:
Central combat sequencer for one lane. It is the driver side of the unit move/damage interface used by enemy and player unit modules. It divides the system clock into game ticks and, on each tick, issues the move strobe and then the damage strobe. It computes the frontmost enemy and player positions, broadcasts saturated damage totals to each side, and tracks both base health values until game over.

Parameters:
NUM_ENEMY, 4, number of enemy unit slots
NUM_PLAYER, 4, number of player unit slots
TICK_DIV, 24'd2_500_000, clk cycles per game tick (min 4)
ENEMY_BASE_POS, 9'd0, enemy spawn/base position (enemies move upward)
PLAYER_BASE_POS, 9'd300, player base position (players move downward)
BASE_HEALTH, 8'd255, reset health of each base

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  level; ticks advance only while 1
enemyPos  in  9*NUM_ENEMY  slot i at [9i+8:9i]
enemyDamage  in  8*NUM_ENEMY  each enemy's damageOut
enemyAlive  in  NUM_ENEMY  each enemy's q_Alive
playerPos  in  9*NUM_PLAYER  slot j at [9j+8:9j]
playerDamage  in  8*NUM_PLAYER  each player's damageOut
playerAlive  in  NUM_PLAYER  each player's q_Alive
moveSCEN  out  1  one-cycle move strobe to all units
damageSCEN  out  1  one-cycle damage strobe to all units
enemyDamageIn  out  8  damage broadcast to enemies
playerDamageIn  out  8  damage broadcast to players
enemyUnitFront  out  9  front seen by enemies (frontmost player)
playerUnitFront  out  9  front seen by players (frontmost enemy)
enemyBaseHealth  out  8  remaining enemy base health
playerBaseHealth  out  8  remaining player base health
playerWin  out  1  enemy base destroyed
playerLose  out  1  player base destroyed
q_I, q_Wait, q_Move, q_Settle, q_Damage, q_Over  out  1 each  one-hot state

Behaviour:
- Reset values:
  - State = QI.
  - tick counter = 0.
  - moveSCEN = damageSCEN = 0.
  - Both DamageIn outputs = 0.
  - enemyUnitFront = PLAYER_BASE_POS.
  - playerUnitFront = ENEMY_BASE_POS.
  - Base healths = BASE_HEALTH.
  - Win/lose flags = 0.
- Fronts, registered every cycle in all states:
  - playerUnitFront = max enemyPos over slots with enemyAlive=1; ENEMY_BASE_POS if none are alive.
  - enemyUnitFront = min playerPos over slots with playerAlive=1; PLAYER_BASE_POS if none are alive.
  - Latency is 1 cycle from an input change.
- Sums:
  - eSum = sum of enemyDamage over alive enemies; pSum = sum of playerDamage over alive players.
  - Computed 11 bits wide, then saturated to 8'd255.
- FSM (one-hot, Moore strobes):
  - QI: go to QWait next cycle; clear tick counter.
  - QWait:
    - When enable=1, increment the counter.
    - When counter == TICK_DIV-4, clear it and go to QMove.
    - When enable=0, hold the counter.
  - QMove: moveSCEN=1 for exactly this cycle; go to QSettle. Units update damageOut on the edge leaving QMove.
  - QSettle:
    - Register playerDamageIn <= eSum and enemyDamageIn <= pSum; go to QDamage.
    - If playerAlive==0, playerBaseHealth <= sat0(playerBaseHealth - eSum).
    - If enemyAlive==0, enemyBaseHealth <= sat0(enemyBaseHealth - pSum).
    - sat0 clamps at 0; no wrap.
  - QDamage:
    - damageSCEN=1 for exactly this cycle; DamageIn outputs are stable throughout.
    - If either base health == 0: set playerWin (enemy base 0) and/or playerLose (player base 0); both may be set; go to QOver.
    - Otherwise go to QWait.
  - QOver: strobes held 0, DamageIn outputs forced to 0, flags held; exit only via reset.
- Tick period: exactly TICK_DIV cycles from one moveSCEN rising edge to the next while enable=1.
- Strobes are never both high in the same cycle.
- DamageIn outputs change only on the edge leaving QSettle (or on reset/QOver entry). Units see them unchanged while damageSCEN=1.
- enable dropping outside QWait does not abort the current Move/Settle/Damage sequence.
- Reset mid-sequence returns all outputs to reset values immediately; no partial strobe.
- Dead slots' positions and damage values are ignored regardless of their content.

Test Plan:
1. TICK_DIV=8, enable=1, no units alive -> moveSCEN pulses at cycles 6, 14, 22…; damageSCEN 2 cycles after each; fronts = 0 / 300.
2. Enemy slots 0,1 alive at 10, 42, slot 2 dead at 200; player slot 0 alive at 150 -> playerUnitFront=42, enemyUnitFront=150, one cycle after the inputs settle.
3. Three alive enemies with damage 0x80 each, players alive -> playerDamageIn=8'hFF (saturated) during damageSCEN; playerBaseHealth unchanged.
4. No players alive, enemy damage 0x20 each tick, BASE_HEALTH=8'h50 -> base health 0x30, 0x10, 0x00; playerLose=1 on the third damage tick, then QOver with no further strobes.
5. enable deasserted for 20 cycles in QWait -> counter holds; the next moveSCEN is delayed exactly 20 cycles.
6. Assert reset during QSettle -> strobes 0, DamageIn=0, healths=BASE_HEALTH, q_I=1 at once; sequence resumes normally after release.
